wb_gpio_debounce: RTL and testbench

Wishbone slave GPIO peripheral for the Arty A7 SoC. It drives the four board LEDs and presents debounced, synchronized switch and button inputs to the Ibex core. It optionally latches rising edges and raises a level interrupt. It sits between the board pins (`sw`, `btn`, `led`) and the SoC Wishbone interconnect as an additional slave next to the SPRAM.

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_debounce.sv | 40 ++++
 rtl/wb_gpio_debounce.sv | 114 +++++++++++
 tb/tb_wb_gpio_debounce.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO constants: register byte offsets, pin counts and the input-vector type.
package gpio_pkg;
    localparam int NUM_IN  = 8;
    localparam int NUM_LED = 4;

    localparam logic [3:0] GPIO_LED    = 4'h0;
    localparam logic [3:0] GPIO_IN     = 4'h4;
    localparam logic [3:0] GPIO_EDGE   = 4'h8;
    localparam logic [3:0] GPIO_IRQ_EN = 4'hC;

    typedef logic [NUM_IN-1:0] gpio_in_t;
endpackage

// File: rtl/gpio_debounce.sv
// Single-bit synchronizer plus debouncer; output follows the pin after SYNC_STAGES-1+DEBOUNCE_CYCLES edges.
// No handshake: pure sampling pipeline, never stalls.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   stable;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];
    assign dout   = stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            // Any cycle where the synchronized value agrees with stable restarts the count.
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= synced;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/wb_gpio_debounce.sv
// Wishbone GPIO slave: LEDs, debounced {btn,sw}, and (with GPIO_IRQ_EN) rising-edge latch + level irq.
// Latency: ack one cycle after cyc&stb, back-to-back capable; wb_stall is tied low (never backpressures).
module wb_gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_cyc,
    input  logic               wb_stb,
    input  logic               wb_we,
    input  logic [3:0]         wb_adr,
    input  logic [3:0]         wb_sel,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack,
    output logic               wb_stall,
    input  logic [3:0]         sw,
    input  logic [3:0]         btn,
    output logic [NUM_LED-1:0] led,
    output logic               irq
);
    gpio_in_t   in_raw;
    gpio_in_t   in_stable;
    gpio_in_t   edge_q;
    gpio_in_t   irq_en_q;
    logic       acc;
    logic       wr;
    logic [3:0] reg_off;
    logic [31:0] rdata;
    logic       unused;

    assign in_raw   = {btn, sw};
    assign acc      = wb_cyc & wb_stb;
    assign wr       = acc & wb_we & wb_sel[0];
    assign reg_off  = {wb_adr[3:2], 2'b00};
    assign wb_stall = 1'b0;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (in_raw[i]),
            .dout (in_stable[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else if (wr && reg_off == GPIO_LED) begin
            led <= wb_dat_i[NUM_LED-1:0];
        end
    end

`ifdef GPIO_IRQ_EN
    gpio_in_t stable_d;
    gpio_in_t rise;
    gpio_in_t edge_clr;

    assign rise     = in_stable & ~stable_d;
    assign edge_clr = (wr && reg_off == GPIO_EDGE) ? wb_dat_i[NUM_IN-1:0] : '0;

    // Set is OR'ed after the clear so a same-cycle set survives a W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            irq      <= 1'b0;
        end else begin
            stable_d <= in_stable;
            edge_q   <= (edge_q & ~edge_clr) | rise;
            if (wr && reg_off == GPIO_IRQ_EN) begin
                irq_en_q <= wb_dat_i[NUM_IN-1:0];
            end
            irq <= |(edge_q & irq_en_q);
        end
    end

    assign unused = ^{wb_adr[1:0], wb_sel[3:1], wb_dat_i[31:NUM_IN]};
`else
    assign edge_q   = '0;
    assign irq_en_q = '0;
    assign irq      = 1'b0;
    assign unused   = ^{wb_adr[1:0], wb_sel[3:1], wb_dat_i[31:NUM_LED]};
`endif

    always_comb begin
        rdata = '0;
        case (reg_off)
            GPIO_LED:    rdata[NUM_LED-1:0] = led;
            GPIO_IN:     rdata[NUM_IN-1:0]  = in_stable;
            GPIO_EDGE:   rdata[NUM_IN-1:0]  = edge_q;
            GPIO_IRQ_EN: rdata[NUM_IN-1:0]  = irq_en_q;
            default:     rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack   <= acc;
            wb_dat_o <= acc ? rdata : '0;
        end
    end
endmodule

// File: tb/tb_wb_gpio_debounce.sv
// Directed bench for wb_gpio_debounce: read data checked against a scoreboard queue as acks arrive.
module tb_wb_gpio_debounce;
    localparam int DC = 4;
    localparam int SS = 2;
`ifdef GPIO_IRQ_EN
    localparam bit IRQB = 1'b1;
`else
    localparam bit IRQB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_adr = '0, wb_sel = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack, wb_stall;
    logic [3:0]  sw = '0, btn = '0;
    logic [3:0]  led;
    logic        irq;

    wb_gpio_debounce #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack(wb_ack), .wb_stall(wb_stall),
        .sw(sw), .btn(btn), .led(led), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_ack) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL ack_without_request: observed ack=1 expected ack=0");
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                if (mon_e.is_rd) chk(mon_e.tag, wb_dat_o, mon_e.exp);
            end
        end
    end

    // Present one request for one cycle; returns at the negedge where its ack must be visible.
    task automatic req(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string tag);
        exp_t e;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
        e.is_rd = !we; e.exp = exp; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "_ack"}, 32'(wb_ack), 32'd1);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        req(1'b0, adr, 32'h0, 4'hF, exp, tag);
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        req(1'b1, adr, dat, 4'hF, 32'h0, "wr");
    endtask

    task automatic idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 32'(wb_ack), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LED write: led changes on the accepting edge, ack one cycle later
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 4'h0; wb_sel = 4'hF; wb_dat_i = 32'h5;
        sb.push_back('{1'b0, 32'h0, "wr_led"});
        @(posedge clk); #1;
        chk("led_on_accept_edge", 32'(led), 32'h5);
        @(negedge clk);
        chk("wr_led_ack", 32'(wb_ack), 32'd1);
        rd(4'h0, 32'h5, "rd_led");
        req(1'b1, 4'h0, 32'hA, 4'hE, 32'h0, "wr_sel0_low");
        rd(4'h0, 32'h5, "rd_led_after_sel0_low");
        chk("led_pins", 32'(led), 32'h5);
        wr(4'h4, 32'hFF);
        rd(4'h8, 32'h0, "rd_edge_rst");
        rd(4'hC, 32'h0, "rd_irqen_rst");
        idle();

        // Debounce accept: sampled at E0, stable at E0+5, visible to reads accepted from E0+6
        sw = 4'b0001;
        for (int k = 0; k < 8; k++) rd(4'h4, (k >= 6) ? 32'h1 : 32'h0, $sformatf("in_debounce_k%0d", k));
        idle();
        rd(4'h8, IRQB ? 32'h1 : 32'h0, "edge_sw0");
        wr(4'h8, 32'hFF);
        rd(4'h8, 32'h0, "edge_cleared");
        idle();

        // Glitch reject: 3-cycle pulse on btn[2]
        btn = 4'b0100;
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        rd(4'h4, 32'h1, "in_after_glitch");
        rd(4'h8, 32'h0, "edge_after_glitch");
        idle();

        // Edge/IRQ on btn[0] (input bit 4)
        wr(4'hC, 32'h10);
        rd(4'hC, IRQB ? 32'h10 : 32'h0, "rd_irqen");
        idle();
        btn = 4'b0001;
        repeat (7) @(negedge clk);
        chk("irq_before", 32'(irq), 32'd0);
        @(negedge clk);
        chk("irq_rise", 32'(irq), IRQB ? 32'd1 : 32'd0);
        rd(4'h8, IRQB ? 32'h10 : 32'h0, "edge_btn0");
        req(1'b1, 4'h8, 32'h10, 4'hF, 32'h0, "w1c_btn0");
        chk("irq_hold", 32'(irq), IRQB ? 32'd1 : 32'd0);
        idle();
        chk("irq_fall", 32'(irq), 32'd0);
        rd(4'h8, 32'h0, "edge_after_w1c");
        idle();

        // Collision: W1C of bit 0 accepted at the edge where bit 0 sets
        sw = 4'b0000;
        repeat (10) @(negedge clk);
        sw = 4'b0001;
        repeat (6) @(negedge clk);
        req(1'b1, 4'h8, 32'h1, 4'hF, 32'h0, "w1c_collide");
        rd(4'h8, IRQB ? 32'h1 : 32'h0, "edge_collision");
        idle();
        chk("irq_not_enabled", 32'(irq), 32'd0);

        // Reset mid-operation drops the pending ack
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h0; wb_sel = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", 32'(wb_ack), 32'd0);
        chk("midrst_led", 32'(led), 32'd0);
        chk("midrst_dat", wb_dat_o, 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        sb.delete();
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'h4, 32'h0, "in_after_rst");
        idle();
        repeat (10) @(negedge clk);
        rd(4'h4, 32'h11, "in_held_through_rst");
        rd(4'h8, IRQB ? 32'h11 : 32'h0, "edge_held_through_rst");
        rd(4'h0, 32'h0, "led_after_rst");
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
